// File: rtl/bcd_convertidor_resultado_if.sv
// Result bus between the converter and the display side: the start/value request
// and the BCD/sign result with busy/done status.
interface bcd_convertidor_resultado_if #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
);
  logic                  start;
  logic [WIDTH-1:0]      bin_in;
  logic [4*DIGITS-1:0]   bcd;
  logic                  neg;
  logic                  busy;
  logic                  done;

  modport master (output start, bin_in, input bcd, neg, busy, done);
  modport slave  (input start, bin_in, output bcd, neg, busy, done);
endinterface

// File: rtl/bcd_convertidor_resultado.sv
// Sequential signed-binary to BCD converter (double dabble), one bit per cycle.
// Optional macro BCD_BLANK_EN replaces leading zero digits with the blank code 4'hF.
//
// state | meaning
// IDLE  | waiting for start; last result held
// CONV  | shift-add-3 iterations, WIDTH cycles
// FIN   | publish bcd/neg, pulse done
module bcd_convertidor_resultado #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic clk,
  input  logic reset,
  bcd_convertidor_resultado_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CONV, FIN} state_t;

  state_t               state;
  logic [WIDTH-1:0]     mag;
  logic [4*DIGITS-1:0]  scratch;
  logic [4*DIGITS-1:0]  adj;
  logic [4*DIGITS-1:0]  result;
  logic [CW-1:0]        cnt;
  logic                 neg_r;
  logic [4*DIGITS-1:0]  bcd_r;
  logic                 neg_o;
  logic                 busy_o;
  logic                 done_o;

  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

`ifdef BCD_BLANK_EN
  logic lead;
  // Walk down from the top digit; digit 0 is never blanked so zero shows as "0".
  always_comb begin
    result = scratch;
    lead   = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lead && scratch[4*i +: 4] == 4'd0) result[4*i +: 4] = 4'hF;
      else                                   lead = 1'b0;
    end
  end
`else
  assign result = scratch;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      mag     <= '0;
      scratch <= '0;
      cnt     <= '0;
      neg_r   <= 1'b0;
      bcd_r   <= '0;
      neg_o   <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            // Two's-complement negate in WIDTH bits; the most negative value maps to 2^(WIDTH-1).
            mag     <= bus.bin_in[WIDTH-1] ? (~bus.bin_in + WIDTH'(1)) : bus.bin_in;
            neg_r   <= bus.bin_in[WIDTH-1];
            scratch <= '0;
            cnt     <= CW'(WIDTH);
            busy_o  <= 1'b1;
            state   <= CONV;
          end
        end
        CONV: begin
          scratch <= {adj[4*DIGITS-2:0], mag[WIDTH-1]};
          mag     <= {mag[WIDTH-2:0], 1'b0};
          cnt     <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FIN;
        end
        FIN: begin
          bcd_r  <= result;
          neg_o  <= neg_r;
          done_o <= 1'b1;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.bcd  = bcd_r;
  assign bus.neg  = neg_o;
  assign bus.busy = busy_o;
  assign bus.done = done_o;
endmodule
